// File: rtl/vec_alu_seq.sv
// vec_alu_seq: issue-side sequencer for the multi-lane vector ALU wrapper.
// Accepts one vector command, reads vs2 (and vs1 for VV) from the register
// file, broadcasts scalar/immediate operands for VX/VI, runs the ALU wrapper
// until done, assembles lane slices into a VLEN-bit result, writes it back
// and retires the command.
// Optional feature: define VEC_SEQ_TIMEOUT_EN to enable the RUN watchdog.
module vec_alu_seq #(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 4,
  parameter int NB_LANES   = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [5:0]      cmd_opcode,
  input  logic [2:0]      cmd_op_type,
  input  logic [2:0]      cmd_vsew,
  input  logic [4:0]      cmd_vd,
  input  logic [4:0]      cmd_vs1,
  input  logic [4:0]      cmd_vs2,
  input  logic [31:0]     cmd_scalar,
  output logic            rsp_valid,
  output logic            rsp_err,
  output logic            vrf_re,
  output logic [4:0]      vrf_raddr,
  input  logic [VLEN-1:0] vrf_rdata,
  output logic            vrf_we,
  output logic [4:0]      vrf_waddr,
  output logic [VLEN-1:0] vrf_wdata,
  output logic            alu_run,
  output logic [5:0]      alu_opcode,
  output logic [2:0]      alu_op_type,
  output logic [2:0]      alu_vsew,
  output logic [VLEN-1:0] alu_vs1,
  output logic [VLEN-1:0] alu_vs2,
  input  logic [63:0]     alu_vd0,
  input  logic [63:0]     alu_vd1,
  input  logic [63:0]     alu_vd2,
  input  logic [63:0]     alu_vd3,
  input  logic [9:0]      alu_regi0,
  input  logic [9:0]      alu_regi1,
  input  logic [9:0]      alu_regi2,
  input  logic [9:0]      alu_regi3,
  input  logic            alu_res0,
  input  logic            alu_res1,
  input  logic            alu_res2,
  input  logic            alu_res3,
  input  logic            alu_done
);

  localparam int AW = $clog2(VLEN);
  // The wrapper exposes four lane ports; fewer lanes simply leave the rest unused.
  localparam int NL = (NB_LANES >= 2) ? 4 : (1 << NB_LANES);
  localparam logic [2:0] OP_VV = 3'b001;

  typedef enum logic [2:0] {S_IDLE, S_RD1, S_RD2, S_RUN, S_WB, S_RSP} state_t;

  state_t            r_state;
  logic [5:0]        r_opcode;
  logic [2:0]        r_op_type;
  logic [2:0]        r_vsew;
  logic [4:0]        r_vd;
  logic [4:0]        r_vs1_idx;
  logic [31:0]       r_scalar;
  logic              r_err;
  logic              r_first;
  logic [VLEN-1:0]   r_vs1;
  logic [VLEN-1:0]   r_vs2;
  logic [VLEN-1:0]   r_acc;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic              r_vrf_re;
  logic [4:0]        r_vrf_raddr;
  logic              r_vrf_we;
  logic [4:0]        r_vrf_waddr;
  logic [VLEN-1:0]   r_vrf_wdata;
  logic              r_alu_run;

  logic [63:0]       w_vd [4];
  logic [9:0]        w_regi [4];
  logic [3:0]        w_res;
  logic [6:0]        w_sew_bits;
  logic [6:0]        w_lane_bits;
  logic [6:0]        w_slice_w;
  logic [10:0]       w_idx;
  logic [VLEN-1:0]   w_acc_next;
  logic [VLEN-1:0]   w_vs1;
  logic              w_is_vv;
  logic              w_illegal;
  logic              w_timeout;

  // Replicate the low SEW bits of the scalar across the vector; SEW=64 sign-extends.
  function automatic logic [VLEN-1:0] f_bcast(input logic [1:0] vsew,
                                               input logic [31:0] s);
    logic signed [63:0] s64;
    s64 = 64'($signed(s));
    case (vsew)
      2'd0:    return {(VLEN/8){s[7:0]}};
      2'd1:    return {(VLEN/16){s[15:0]}};
      2'd2:    return {(VLEN/32){s}};
      default: return {(VLEN/64){s64}};
    endcase
  endfunction

  assign w_vd[0]   = alu_vd0;
  assign w_vd[1]   = alu_vd1;
  assign w_vd[2]   = alu_vd2;
  assign w_vd[3]   = alu_vd3;
  assign w_regi[0] = alu_regi0;
  assign w_regi[1] = alu_regi1;
  assign w_regi[2] = alu_regi2;
  assign w_regi[3] = alu_regi3;
  assign w_res     = {alu_res3, alu_res2, alu_res1, alu_res0};

  assign w_is_vv     = (r_op_type == OP_VV);
  assign w_illegal   = (cmd_vsew > 3'd3) || !$onehot(cmd_op_type);
  assign w_sew_bits  = 7'd8 << r_vsew[1:0];
  assign w_lane_bits = 7'(1 << LANE_WIDTH);
  assign w_slice_w   = (w_sew_bits < w_lane_bits) ? w_sew_bits : w_lane_bits;

  // The vs1 read returns in the first RUN cycle; forward it so the ALU sees
  // the correct operand for the whole of RUN.
  assign w_vs1 = (r_state == S_RUN && r_first && w_is_vv) ? vrf_rdata : r_vs1;

  // Deposit each valid lane slice into the accumulator, dropping bits at or above VLEN.
  always_comb begin
    w_acc_next = r_acc;
    w_idx      = '0;
    for (int l = 0; l < NL; l++) begin
      if (w_res[l]) begin
        for (int b = 0; b < 64; b++) begin
          if (7'(b) < w_slice_w) begin
            w_idx = 11'(w_regi[l]) + 11'(b);
            if (w_idx < 11'(VLEN))
              w_acc_next[w_idx[AW-1:0]] = w_vd[l][b];
          end
        end
      end
    end
  end

`ifdef VEC_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1) + 1;
  logic [TW-1:0] r_tcnt;

  // Count cycles spent in RUN; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_tcnt <= '0;
    else if (r_state == S_RUN)
      r_tcnt <= r_tcnt + 1'b1;
    else
      r_tcnt <= '0;
  end

  assign w_timeout = (r_state == S_RUN) && (r_tcnt == TW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Command FSM with registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_opcode    <= '0;
      r_op_type   <= '0;
      r_vsew      <= '0;
      r_vd        <= '0;
      r_vs1_idx   <= '0;
      r_scalar    <= '0;
      r_err       <= 1'b0;
      r_first     <= 1'b0;
      r_vs1       <= '0;
      r_vs2       <= '0;
      r_acc       <= '0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_vrf_re    <= 1'b0;
      r_vrf_raddr <= '0;
      r_vrf_we    <= 1'b0;
      r_vrf_waddr <= '0;
      r_vrf_wdata <= '0;
      r_alu_run   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_opcode    <= cmd_opcode;
            r_op_type   <= cmd_op_type;
            r_vsew      <= cmd_vsew;
            r_vd        <= cmd_vd;
            r_vs1_idx   <= cmd_vs1;
            r_scalar    <= cmd_scalar;
            r_cmd_ready <= 1'b0;
            if (w_illegal) begin
              r_err       <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_state     <= S_RSP;
            end else begin
              r_err       <= 1'b0;
              r_acc       <= '0;
              r_vrf_re    <= 1'b1;
              r_vrf_raddr <= cmd_vs2;
              r_state     <= S_RD1;
            end
          end
        end
        S_RD1: begin
          r_vrf_re <= w_is_vv;
          if (w_is_vv)
            r_vrf_raddr <= r_vs1_idx;
          r_state <= S_RD2;
        end
        S_RD2: begin
          r_vs2 <= vrf_rdata;
          if (!w_is_vv)
            r_vs1 <= f_bcast(r_vsew[1:0], r_scalar);
          r_vrf_re  <= 1'b0;
          r_alu_run <= 1'b1;
          r_first   <= 1'b1;
          r_state   <= S_RUN;
        end
        S_RUN: begin
          r_first <= 1'b0;
          r_acc   <= w_acc_next;
          if (r_first && w_is_vv)
            r_vs1 <= vrf_rdata;
          if (alu_done) begin
            r_alu_run   <= 1'b0;
            r_vrf_we    <= 1'b1;
            r_vrf_waddr <= r_vd;
            r_vrf_wdata <= w_acc_next;
            r_state     <= S_WB;
          end else if (w_timeout) begin
            r_alu_run   <= 1'b0;
            r_err       <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_state     <= S_RSP;
          end
        end
        S_WB: begin
          r_vrf_we    <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= r_err;
          r_state     <= S_RSP;
        end
        S_RSP: begin
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_err     = r_rsp_err;
  assign vrf_re      = r_vrf_re;
  assign vrf_raddr   = r_vrf_raddr;
  assign vrf_we      = r_vrf_we;
  assign vrf_waddr   = r_vrf_waddr;
  assign vrf_wdata   = r_vrf_wdata;
  assign alu_run     = r_alu_run;
  assign alu_opcode  = r_opcode;
  assign alu_op_type = r_op_type;
  assign alu_vsew    = r_vsew;
  assign alu_vs1     = w_vs1;
  assign alu_vs2     = r_vs2;

endmodule

// File: tb/tb_vec_alu_seq.sv
// Testbench for vec_alu_seq: register-file model, lane-slicing ALU model,
// table of commands plus hand-written corner-case sequences.
module tb_vec_alu_seq;

  localparam int VLEN = 128;
  localparam int TMO  = 10;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [5:0]      cmd_opcode = '0;
  logic [2:0]      cmd_op_type = '0;
  logic [2:0]      cmd_vsew = '0;
  logic [4:0]      cmd_vd = '0;
  logic [4:0]      cmd_vs1 = '0;
  logic [4:0]      cmd_vs2 = '0;
  logic [31:0]     cmd_scalar = '0;
  logic            rsp_valid, rsp_err;
  logic            vrf_re, vrf_we;
  logic [4:0]      vrf_raddr, vrf_waddr;
  logic [VLEN-1:0] vrf_rdata = '0;
  logic [VLEN-1:0] vrf_wdata;
  logic            alu_run;
  logic [5:0]      alu_opcode;
  logic [2:0]      alu_op_type, alu_vsew;
  logic [VLEN-1:0] alu_vs1, alu_vs2;
  logic [63:0]     m_vd [4];
  logic [9:0]      m_regi [4];
  logic            m_res [4];
  logic            m_done;

  vec_alu_seq #(.VLEN(VLEN), .LANE_WIDTH(4), .NB_LANES(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_op_type(cmd_op_type), .cmd_vsew(cmd_vsew),
    .cmd_vd(cmd_vd), .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_scalar(cmd_scalar),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .vrf_re(vrf_re), .vrf_raddr(vrf_raddr), .vrf_rdata(vrf_rdata),
    .vrf_we(vrf_we), .vrf_waddr(vrf_waddr), .vrf_wdata(vrf_wdata),
    .alu_run(alu_run), .alu_opcode(alu_opcode), .alu_op_type(alu_op_type),
    .alu_vsew(alu_vsew), .alu_vs1(alu_vs1), .alu_vs2(alu_vs2),
    .alu_vd0(m_vd[0]), .alu_vd1(m_vd[1]), .alu_vd2(m_vd[2]), .alu_vd3(m_vd[3]),
    .alu_regi0(m_regi[0]), .alu_regi1(m_regi[1]), .alu_regi2(m_regi[2]), .alu_regi3(m_regi[3]),
    .alu_res0(m_res[0]), .alu_res1(m_res[1]), .alu_res2(m_res[2]), .alu_res3(m_res[3]),
    .alu_done(m_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]      op_type;
    logic [2:0]      vsew;
    logic [31:0]     scalar;
    logic [VLEN-1:0] vs1v;
    logic [VLEN-1:0] vs2v;
    logic [VLEN-1:0] exp_vs1;
    logic [VLEN-1:0] exp_wd;
    int              done_at;
    logic            err;
  } vec_t;

  logic [VLEN-1:0] mem [32];
  int              cyc = 0;
  int              rc = 0;
  int              done_at = 0;
  bit              man_en = 1'b0;
  logic [63:0]     man_vd = '0;
  logic [9:0]      man_regi = '0;
  logic            man_res = 1'b0;
  logic            man_done = 1'b0;

  int              checks = 0;
  int              errors = 0;
  int              re_tot = 0, we_tot = 0, run_tot = 0, rsp_tot = 0, rsp_cyc = 0;
  bit              vs1_bad = 1'b0;
  logic [VLEN-1:0] exp_vs1 = '0;
  logic [VLEN-1:0] q_wd [$];
  int              q_wa [$];
  logic            q_err [$];
  vec_t            tbl [9];

  // Register file read port (1-cycle latency) and ALU run-cycle counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rc  <= alu_run ? rc + 1 : 0;
    if (vrf_re) vrf_rdata <= mem[vrf_raddr];
  end

  // Element-wise add at the given SEW.
  function automatic logic [VLEN-1:0] f_add(input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                                            input int sew);
    logic [VLEN-1:0] r;
    logic [63:0]     m, x, y;
    int              sb;
    r  = '0;
    sb = 8 << sew;
    m  = (sb == 64) ? '1 : ((64'(1) << sb) - 64'(1));
    for (int e = 0; e < VLEN / sb; e++) begin
      x = 64'(a >> (e * sb)) & m;
      y = 64'(b >> (e * sb)) & m;
      r = r | (VLEN'((x + y) & m) << (e * sb));
    end
    return r;
  endfunction

  // ALU wrapper model: four slices per RUN cycle, done at run cycle done_at.
  always @* begin
    logic [VLEN-1:0] fr;
    int sw, w, j;
    for (int l = 0; l < 4; l++) begin
      m_vd[l] = '0; m_regi[l] = '0; m_res[l] = 1'b0;
    end
    m_done = 1'b0;
    sw = (alu_vsew > 3'd3) ? 0 : int'(alu_vsew);
    w  = ((8 << sw) < 16) ? (8 << sw) : 16;
    fr = f_add(alu_vs1, alu_vs2, sw);
    j  = 0;
    if (man_en) begin
      m_vd[0] = man_vd; m_regi[0] = man_regi; m_res[0] = man_res; m_done = man_done;
    end else if (alu_run) begin
      for (int l = 0; l < 4; l++) begin
        j = rc * 4 + l;
        if (j < VLEN / w) begin
          m_res[l]  = 1'b1;
          m_regi[l] = 10'(j * w);
          m_vd[l]   = 64'(fr >> (j * w)) & ((64'(1) << w) - 64'(1));
        end
      end
      m_done = (rc == done_at);
    end
  end

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_v(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and run the output monitor/scoreboard.
  task automatic step();
    @(negedge clk);
    if (vrf_re)  re_tot++;
    if (alu_run) run_tot++;
    if (alu_run && alu_vs1 !== exp_vs1) vs1_bad = 1'b1;
    if (vrf_we) begin
      we_tot++;
      if (q_wd.size() == 0) chk_i("unexpected_wb", 1, 0);
      else begin
        chk_v("wb_data", vrf_wdata, q_wd.pop_front());
        chk_i("wb_addr", int'(vrf_waddr), q_wa.pop_front());
      end
    end
    if (rsp_valid) begin
      rsp_tot++;
      rsp_cyc = cyc;
      if (q_err.size() == 0) chk_i("unexpected_rsp", 1, 0);
      else chk_i("rsp_err", int'(rsp_err), int'(q_err.pop_front()));
    end
  endtask

  task automatic drive_cmd(input logic [2:0] op_type, input logic [2:0] vsew, input logic [31:0] scalar);
    cmd_opcode = 6'h01; cmd_op_type = op_type; cmd_vsew = vsew;
    cmd_vd = 5'd3; cmd_vs1 = 5'd1; cmd_vs2 = 5'd2; cmd_scalar = scalar;
    cmd_valid = 1'b1;
  endtask

  task automatic scramble_cmd();
    cmd_valid = 1'b0; cmd_op_type = 3'b111; cmd_vsew = 3'd7;
    cmd_vd = 5'd9; cmd_vs1 = 5'd7; cmd_vs2 = 5'd7; cmd_scalar = 32'h5A5A_5A5A;
  endtask

  task automatic run_vec(input vec_t v, input bit exp_to);
    bit legal;
    int t0, re0, we0, run0, rsp0, exp_lat, exp_re, exp_run;
    legal = (v.vsew <= 3'd3) && $onehot(v.op_type);
    mem[1] = v.vs1v; mem[2] = v.vs2v;
    done_at = v.done_at;
    if (legal && !exp_to) begin
      q_wd.push_back(v.exp_wd); q_wa.push_back(3);
    end
    q_err.push_back(v.err | exp_to);
    exp_vs1 = v.exp_vs1; vs1_bad = 1'b0;
    re0 = re_tot; we0 = we_tot; run0 = run_tot; rsp0 = rsp_tot;
    drive_cmd(v.op_type, v.vsew, v.scalar);
    t0 = cyc;
    step();
    scramble_cmd();
    chk_i("ready_busy", int'(cmd_ready), 0);
    for (int i = 0; i < 200 && rsp_tot == rsp0; i++) step();
    chk_i("rsp_count", rsp_tot - rsp0, 1);
    exp_lat = !legal ? 1 : (exp_to ? 3 + TMO : v.done_at + 5);
    chk_i("rsp_latency", rsp_cyc - t0, exp_lat);
    step();
    chk_i("ready_again", int'(cmd_ready), 1);
    exp_re  = !legal ? 0 : ((v.op_type == 3'b001) ? 2 : 1);
    exp_run = !legal ? 0 : (exp_to ? TMO : v.done_at + 1);
    chk_i("vrf_re_count", re_tot - re0, exp_re);
    chk_i("vrf_we_count", we_tot - we0, (legal && !exp_to) ? 1 : 0);
    chk_i("alu_run_count", run_tot - run0, exp_run);
    if (legal) chk_i("alu_vs1_stable", int'(vs1_bad), 0);
  endtask

  initial begin
    vec_t v;
    int rsp0, we0;
    for (int i = 0; i < 32; i++) mem[i] = {(VLEN/8){8'hEE}};
    tbl[0] = '{3'b001, 3'd0, 32'h0, {16{8'h01}}, {16{8'h02}}, {16{8'h01}}, {16{8'h03}}, 4, 1'b0};
    tbl[1] = '{3'b010, 3'd2, 32'hDEADBEEF, '0, {4{32'h1}}, {4{32'hDEADBEEF}}, {4{32'hDEADBEF0}}, 1, 1'b0};
    tbl[2] = '{3'b100, 3'd1, 32'hFFFFFFFF, '0, {8{16'h0005}}, {8{16'hFFFF}}, {8{16'h0004}}, 1, 1'b0};
    tbl[3] = '{3'b001, 3'd3, 32'h0, {2{64'h00000001_FFFFFFFF}}, {2{64'h1}},
               {2{64'h00000001_FFFFFFFF}}, {2{64'h00000002_00000000}}, 3, 1'b0};
    tbl[4] = '{3'b010, 3'd3, 32'h80000000, '0, {2{64'h10}}, {2{64'hFFFFFFFF_80000000}},
               {2{64'hFFFFFFFF_80000010}}, 2, 1'b0};
    tbl[5] = '{3'b010, 3'd0, 32'h123456AB, '0, {16{8'h60}}, {16{8'hAB}}, {16{8'h0B}}, 3, 1'b0};
    tbl[6] = '{3'b001, 3'd5, 32'h0, '0, '0, '0, '0, 0, 1'b1};
    tbl[7] = '{3'b011, 3'd0, 32'h0, '0, '0, '0, '0, 0, 1'b1};
    tbl[8] = '{3'b000, 3'd1, 32'h0, '0, '0, '0, '0, 0, 1'b1};

    // Reset state
    step();
    step();
    chk_i("rst_cmd_ready", int'(cmd_ready), 1);
    chk_i("rst_ctrl", int'({rsp_valid, rsp_err, vrf_re, vrf_we, alu_run}), 0);
    chk_v("rst_wdata", vrf_wdata, '0);
    chk_v("rst_alu_vs1", alu_vs1, '0);
    resetn = 1'b1;
    step();
    chk_i("post_rst_ready", int'(cmd_ready), 1);
    chk_i("post_rst_addr", int'({vrf_raddr, vrf_waddr, alu_opcode}), 0);

    // Table-driven commands
    for (int i = 0; i < 9; i++) run_vec(tbl[i], 1'b0);

    // alu_done while idle is ignored
    rsp0 = rsp_tot;
    man_en = 1'b1; man_done = 1'b1;
    step(); step(); step();
    chk_i("idle_done_rsp", rsp_tot - rsp0, 0);
    chk_i("idle_done_state", int'({cmd_ready, alu_run, vrf_we}), 3'b100);
    man_done = 1'b0;

    // Top lane slice straddling VLEN: only bits [127:120] land, nothing wraps
    q_wd.push_back({8'hC3, 120'h0}); q_wa.push_back(3); q_err.push_back(1'b0);
    mem[2] = '0; exp_vs1 = '0;
    rsp0 = rsp_tot;
    drive_cmd(3'b010, 3'd1, 32'h0);
    step();
    scramble_cmd();
    for (int i = 0; i < 20 && !alu_run; i++) step();
    chk_i("edge_run_seen", int'(alu_run), 1);
    man_res = 1'b1; man_regi = 10'd120; man_vd = 64'hFFFF_FFFF_FFFF_A5C3; man_done = 1'b1;
    step();
    man_res = 1'b0; man_done = 1'b0;
    for (int i = 0; i < 20 && rsp_tot == rsp0; i++) step();
    chk_i("edge_rsp", rsp_tot - rsp0, 1);
    man_en = 1'b0;
    step();

    // Asynchronous reset in RUN: no write-back, no response
    v = tbl[0];
    mem[1] = v.vs1v; mem[2] = v.vs2v;
    done_at = 9999;
    rsp0 = rsp_tot; we0 = we_tot;
    drive_cmd(v.op_type, v.vsew, 32'h0);
    step();
    scramble_cmd();
    for (int i = 0; i < 20 && !alu_run; i++) step();
    chk_i("rstrun_run_seen", int'(alu_run), 1);
    step();
    #2 resetn = 1'b0;
    #1;
    chk_i("rstrun_ready", int'(cmd_ready), 1);
    chk_i("rstrun_ctrl", int'({rsp_valid, rsp_err, vrf_re, vrf_we, alu_run}), 0);
    chk_v("rstrun_vs2", alu_vs2, '0);
    chk_v("rstrun_wdata", vrf_wdata, '0);
    step();
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk_i("rstrun_no_rsp", rsp_tot - rsp0, 0);
    chk_i("rstrun_no_wb", we_tot - we0, 0);
    run_vec(tbl[0], 1'b0);

`ifdef VEC_SEQ_TIMEOUT_EN
    // Watchdog: ALU never finishes
    v = tbl[1];
    v.done_at = 9999;
    run_vec(v, 1'b1);
`endif

    chk_i("queues_drained", q_wd.size() + q_err.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_alu_seq.md
# vec_alu_seq

Issue-side sequencer for the multi-lane vector ALU wrapper. It accepts one vector arithmetic command at a time from the core, reads the source vector registers from the vector register file, broadcasts scalar/immediate operands for VX/VI forms, holds `run` on the ALU wrapper until its `done_out`, and assembles the per-lane result slices into a VLEN-bit destination word. It then writes that word back to the register file and retires the command to the core.

## Interface
Parameters:
- `VLEN`, 128: vector register width in bits (legal 64..512, power of two).
- `LANE_WIDTH`, 4: log2 lane slice width in bits, matching the ALU wrapper.
- `NB_LANES`, 2: log2 lane count, matching the ALU wrapper.
- `TIMEOUT`, 255: watchdog limit in cycles, used only with `VEC_SEQ_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: asynchronous active-low reset. Single clock; all state resets asynchronously on `resetn` low.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake. Transfer when both are high.
- `cmd_opcode` in 6, `cmd_op_type` in 3 (VV=001, VX=010, VI=100), `cmd_vsew` in 3.
- `cmd_vd`, `cmd_vs1`, `cmd_vs2` in 5 each: register indices.
- `cmd_scalar` in 32: rs1 value (VX) or sign-extended imm5 (VI).
- `rsp_valid` out 1: one-cycle retire pulse. `rsp_err` out 1: qualifies `rsp_valid`.
- `vrf_re` out 1, `vrf_raddr` out 5, `vrf_rdata` in VLEN: register-file read port with 1-cycle read latency.
- `vrf_we` out 1, `vrf_waddr` out 5, `vrf_wdata` out VLEN: register-file write port.
- `alu_run` out 1, `alu_opcode` out 6, `alu_op_type` out 3, `alu_vsew` out 3, `alu_vs1` out VLEN, `alu_vs2` out VLEN: drive the ALU wrapper.
- `alu_vd0..3` in 64, `alu_regi0..3` in 10, `alu_res0..3` in 1, `alu_done` in 1: returns from the ALU wrapper.

## Operation
- FSM states: IDLE, RD1, RD2, RUN, WB, RSP.
- IDLE:
  - `cmd_ready`=1.
  - On a transfer, latch all `cmd_*` fields.
  - If `cmd_vsew`>3 or `cmd_op_type` is not one-hot, go to RSP with error set.
  - Otherwise clear the accumulator and go to RD1.
- RD1: `vrf_re`=1, `vrf_raddr`=vs2 → RD2.
- RD2:
  - Capture `vrf_rdata` into vs2.
  - For VV: `vrf_re`=1, `vrf_raddr`=vs1.
  - For VX/VI: build vs1 by replicating the low SEW bits of scalar (SEW=8<<vsew; scalar truncated, or sign-extended for SEW=64) across VLEN.
  - → RUN.
- RUN:
  - On entry (VV only), capture `vrf_rdata` into vs1.
  - `alu_run`=1.
  - Every RUN cycle, for each lane i with `alu_res_i`=1: write `alu_vd_i[W-1:0]` into accumulator bits [regi_i+W-1 : regi_i], where W=min(8<<vsew, 1<<LANE_WIDTH).
  - Drop any bits at or above VLEN.
  - The cycle with `alu_done`=1 is also deposited; then → WB.
- WB: `vrf_we`=1, `vrf_waddr`=vd, `vrf_wdata`=accumulator → RSP.
- RSP: `rsp_valid`=1, `rsp_err`=error flag → IDLE.
- `alu_opcode`, `alu_op_type`, `alu_vsew`, `alu_vs1`, `alu_vs2` come from latched registers and are stable throughout RUN.
- `cmd_*` changes after acceptance have no effect.

## Timing
- Reset values:
  - State is IDLE.
  - `cmd_ready`=1.
  - `rsp_valid`, `rsp_err`, `vrf_re`, `vrf_we`, `alu_run` are 0.
  - `vrf_raddr`, `vrf_waddr`, `vrf_wdata`, `alu_*` data outputs, and the accumulator are 0.
- All outputs are registered-state decodes; there is no combinational path from `cmd_valid` to any output except through state.
- Accept at cycle 0:
  - RD1 at cycle 1, RD2 at 2, RUN from 3.
  - With done seen at cycle D: WB at D+1, RSP at D+2, `cmd_ready` high again at D+3.
- Minimum throughput is one command per (D+3) cycles. `cmd_ready` is 0 in all non-IDLE states.
- Illegal command: RSP at cycle 1 with `rsp_err`=1. No VRF or ALU activity.
- `alu_run` falls in the cycle after `alu_done`. This guarantees the wrapper clears its counters before the next command.
- Reset mid-command: FSM returns to IDLE immediately. No write-back or response is produced. A pending `vrf_we` is suppressed.
- `alu_done` outside RUN is ignored.
- Same-index operands (vd=vs1=vs2) are legal: reads complete before WB.

## Configuration
- `VEC_SEQ_TIMEOUT_EN` defined:
  - A cycle counter runs in RUN.
  - If `alu_done` has not arrived after TIMEOUT cycles: drop `alu_run`, skip WB, and go to RSP with `rsp_err`=1.
- Undefined: no counter. RUN waits indefinitely for `alu_done`.

## Test plan
- VV add, vsew=0, VLEN=128, vs1=0x01 bytes, vs2=0x02 bytes, ALU model done at cycle 7 → single `vrf_we` with 0x03 repeated ×16 into vd; `rsp_valid`=1, `rsp_err`=0 at cycle 9.
- VX, vsew=2, scalar=0xDEADBEEF → `alu_vs1`=0xDEADBEEF repeated ×4 throughout RUN; only one `vrf_re` is issued (vs2).
- cmd_vsew=5 → `rsp_valid`=1 with `rsp_err`=1 at cycle 1; `vrf_re`, `vrf_we`, `alu_run` all stay 0.
- Lane slice with regi=120, W=16 at VLEN=128 → only bits [127:120] written; no X or wrap into bit 0.
- `resetn` pulsed low in RUN → all outputs at reset values asynchronously; next command completes normally.
- With `VEC_SEQ_TIMEOUT_EN`, TIMEOUT=10, and the ALU model never asserting done → `alu_run` drops after 10 RUN cycles, `rsp_err`=1, no `vrf_we`.
